carry_seq: RTL and testbench
============================

CARRY_SEQ -- requirements
Module: carry_seq

Interface
REQ-001 Parameter WIDTH, default 16: slice width, equal to the tile adder width.
REQ-002 Parameter SLICES, default 4: number of slices per operation; minimum 2.
REQ-003 Parameter TIMEOUT, default 15: maximum ack-wait cycles per slice (used only with REQ-030).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start_valid / start_ready  in / out  1 / 1  operand handshake.
REQ-007 op_a, op_b  in  WIDTH*SLICES  operands; op_cin in 1, operation carry-in.
REQ-008 add_a, add_b  out  WIDTH  current slice operands driven to the tile adder.
REQ-009 add_carry_in, add_carry_listen, add_on_off  out  1 each  adder carry and control.
REQ-010 add_c  in  WIDTH; add_carry_out in 1; add_ack in 1  adder sum, carry and ack.
REQ-011 res_sum  out  WIDTH*SLICES; res_cout out 1; res_err out 1  result outputs.
REQ-012 res_valid / res_ready  out / in  1 / 1  result handshake.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; start_ready SHALL be 1 only in IDLE.
REQ-014 IDLE->BUSY on start_valid&&start_ready; latch op_a, op_b; running carry<=op_cin; slice index<=0.
REQ-015 In BUSY: add_a/add_b = slice[idx] of latched operands (slice 0 = LSBs); add_carry_in = running carry; add_carry_listen=1; add_on_off=1.
REQ-016 In IDLE/DONE: add_a, add_b, add_carry_in, add_carry_listen, add_on_off SHALL all be 0.
REQ-017 On a BUSY cycle with add_ack=1: res_sum slice[idx]<=add_c; running carry<=add_carry_out; idx<=idx+1.
REQ-018 add_ack=0 in BUSY: hold all adder outputs stable; no capture.
REQ-019 Ack on slice SLICES-1: res_cout<=add_carry_out; go to DONE; idx wraps to 0.
REQ-020 Latency with an always-acking adder: res_valid rises exactly SLICES cycles after the accepting edge.
REQ-021 DONE: res_valid=1; res_sum/res_cout/res_err held stable until res_valid&&res_ready, then IDLE.
REQ-022 start_valid outside IDLE SHALL be ignored; operands are not sampled.
REQ-023 add_ack outside BUSY SHALL be ignored.
REQ-024 Sum arithmetic: {res_cout,res_sum} = op_a+op_b+op_cin, width WIDTH*SLICES+1, no truncation.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE; outputs 0 except start_ready=1.
REQ-026 Reset mid-operation SHALL discard the partial result; no res_valid is produced.
REQ-027 Internal registers (latched operands, idx, carry, timeout counter) SHALL reset to 0.

Configuration
REQ-028 Macro CARRY_SEQ_TIMEOUT_EN SHALL select the ack-timeout feature.
REQ-029 Without the macro: BUSY waits indefinitely for add_ack; res_err is tied to 0; port list is unchanged.
REQ-030 With the macro: per-slice counter cleared on each ack/entry. If TIMEOUT consecutive BUSY cycles pass without ack, go to DONE with res_err=1, res_cout=0, and uncaptured slices 0.

Structure
REQ-031 Package carry_seq_pkg SHALL hold the FSM state enum and the default WIDTH/SLICES/TIMEOUT constants.
REQ-032 No sub-module; the bench SHALL pair carry_seq with the existing tile full adder (carry_listen/ack variant).

Verification (WIDTH=16, SLICES=4)
REQ-033 Reset: assert reset_n=0 -> start_ready=1, res_valid=0, add_on_off=0, res_sum=0.
REQ-034 Carry ripple: op_a=64'h0001_FFFF_FFFF_FFFF, op_b=1, op_cin=0 -> res_sum=64'h0002_0000_0000_0000, res_cout=0, res_valid 4 cycles after accept.
REQ-035 Full carry-out: op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=0, op_cin=1 -> res_sum=0, res_cout=1.
REQ-036 Ack stall and backpressure: adder model delays ack 3 cycles per slice -> add_a stable during the stall, result correct, res_valid 16 cycles after accept; then res_ready held low for 5 cycles -> res_valid/res_sum held, start_valid ignored.
REQ-037 Reset mid-op: reset_n pulsed low while idx=2 -> IDLE, adder outputs 0, no res_valid; the next operation is correct.
REQ-038 Timeout (with CARRY_SEQ_TIMEOUT_EN): add_ack stuck at 0 -> DONE after 15 cycles, res_err=1, res_valid=1.

Source files
------------

// File: rtl/carry_seq_pkg.sv
// Shared types and default sizing for the sequential carry-chained adder
// front end (carry_seq).
package carry_seq_pkg;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 16;  // slice width == tile adder width
    localparam int DEF_SLICES  = 4;   // slices per operation
    localparam int DEF_TIMEOUT = 15;  // ack-wait limit per slice

endpackage

// File: rtl/carry_seq.sv
// carry_seq: performs a WIDTH*SLICES-bit add by feeding one WIDTH-bit slice
// per step to an external tile adder, rippling its carry between slices.
// Optional feature: define CARRY_SEQ_TIMEOUT_EN to abort an operation when
// the adder fails to ack a slice within TIMEOUT BUSY cycles (res_err=1).
module carry_seq
    import carry_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SLICES  = DEF_SLICES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [WIDTH*SLICES-1:0]   op_a,
    input  logic [WIDTH*SLICES-1:0]   op_b,
    input  logic                      op_cin,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    output logic                      add_carry_in,
    output logic                      add_carry_listen,
    output logic                      add_on_off,
    input  logic [WIDTH-1:0]          add_c,
    input  logic                      add_carry_out,
    input  logic                      add_ack,
    output logic [WIDTH*SLICES-1:0]   res_sum,
    output logic                      res_cout,
    output logic                      res_err,
    output logic                      res_valid,
    input  logic                      res_ready
);

    localparam int TOTAL = WIDTH * SLICES;
    localparam int IDX_W = $clog2(SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    // Elaboration-time parameter sanity checks.
    if (SLICES < 2) begin : g_bad_slices
        $error("carry_seq: SLICES must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("carry_seq: TIMEOUT must be at least 1");
    end

    state_t             state, state_nxt;
    logic [TOTAL-1:0]   a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               cout_q;
    logic               last_slice;

    assign last_slice = (idx == LAST_IDX);
    assign res_sum    = sum_q;
    assign res_cout   = cout_q;

`ifdef CARRY_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;
    logic            err_q;

    // Consecutive no-ack BUSY cycles for the current slice; zero outside BUSY
    // so every slice (including the first) starts with a fresh budget.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        to_cnt <= '0;
        else if (state != BUSY || add_ack)   to_cnt <= '0;
        else                                 to_cnt <= to_cnt + 1'b1;
    end

    assign timed_out = (state == BUSY) && !add_ack && (to_cnt == TO_W'(TIMEOUT - 1));
    assign res_err   = err_q;
`else
    assign res_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake/adder-drive decode; adder pins are quiet
    // outside BUSY and hold steady while the adder stalls.
    always_comb begin
        state_nxt        = state;
        start_ready      = 1'b0;
        res_valid        = 1'b0;
        add_a            = '0;
        add_b            = '0;
        add_carry_in     = 1'b0;
        add_carry_listen = 1'b0;
        add_on_off       = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = BUSY;
            end
            BUSY: begin
                add_a            = a_q[int'(idx)*WIDTH +: WIDTH];
                add_b            = b_q[int'(idx)*WIDTH +: WIDTH];
                add_carry_in     = carry;
                add_carry_listen = 1'b1;
                add_on_off       = 1'b1;
                if (add_ack && last_slice) state_nxt = DONE;
`ifdef CARRY_SEQ_TIMEOUT_EN
                if (timed_out)             state_nxt = DONE;
`endif
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, slice capture and carry ripple.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
`ifdef CARRY_SEQ_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
        end else if (state == IDLE && start_valid) begin
            // Clearing the sum here keeps uncaptured slices at 0 on abort.
            a_q    <= op_a;
            b_q    <= op_b;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= op_cin;
            cout_q <= 1'b0;
`ifdef CARRY_SEQ_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
        end else if (state == BUSY) begin
            if (add_ack) begin
                sum_q[int'(idx)*WIDTH +: WIDTH] <= add_c;
                carry <= add_carry_out;
                if (last_slice) begin
                    idx    <= '0;
                    cout_q <= add_carry_out;
                end else begin
                    idx    <= idx + 1'b1;
                end
            end
`ifdef CARRY_SEQ_TIMEOUT_EN
            else if (timed_out) begin
                err_q  <= 1'b1;
                cout_q <= 1'b0;
                idx    <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_carry_seq.sv
// Bench for carry_seq (WIDTH=16, SLICES=4) with a behavioural tile adder
// whose ack can be delayed or withheld.
module tb_carry_seq;

    logic        clk, reset_n;
    logic        start_valid, start_ready;
    logic [63:0] op_a, op_b;
    logic        op_cin;
    logic [15:0] add_a, add_b, add_c;
    logic        add_carry_in, add_carry_listen, add_on_off, add_carry_out, add_ack;
    logic [63:0] res_sum;
    logic        res_cout, res_err, res_valid, res_ready;

    int n_cmp = 0;
    int n_bad = 0;

    carry_seq #(.WIDTH(16), .SLICES(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_carry_in(add_carry_in),
        .add_carry_listen(add_carry_listen), .add_on_off(add_on_off),
        .add_c(add_c), .add_carry_out(add_carry_out), .add_ack(add_ack),
        .res_sum(res_sum), .res_cout(res_cout), .res_err(res_err),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tile full adder model (carry_listen/ack variant).
    logic [16:0] add_full;
    assign add_full      = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_carry_in & add_carry_listen};
    assign add_c         = add_full[15:0];
    assign add_carry_out = add_full[16];

    int ack_delay = 0;
    bit ack_off   = 1'b0;
    int wcnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    wcnt <= 0;
        else if (!add_on_off || add_ack) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end
    assign add_ack = add_on_off && !ack_off && (wcnt >= ack_delay);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for res_valid; lat counts edges
    // after the accepting edge.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         output int lat);
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1);
        op_a = a; op_b = b; op_cin = cin; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) chk("res_valid_wait", res_valid, 1);
    endtask

    task automatic release_res();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("back_to_idle", start_ready, 1);
        chk("valid_dropped", res_valid, 0);
    endtask

    typedef struct {
        logic [63:0] a, b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[6];
    int   lat;
    logic [63:0] held;

    initial begin
        vecs[0] = '{64'h0001_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0002_0000_0000_0000, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0,                   1'b1};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 64'h2345_6789_ABCD_F002, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};

        start_valid = 0; op_a = 0; op_b = 0; op_cin = 0; res_ready = 0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #2;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid",   res_valid,   0);
        chk("rst_on_off",      add_on_off,  0);
        chk("rst_res_sum",     res_sum,     0);
        chk("rst_add_a",       add_a,       0);
        @(negedge clk) reset_n = 1'b1;

        // Table: always-acking adder.
        ack_delay = 0;
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("v%0d_latency", i), lat, 4);
            chk($sformatf("v%0d_sum", i), res_sum, vecs[i].sum);
            chk($sformatf("v%0d_cout", i), res_cout, vecs[i].cout);
            chk($sformatf("v%0d_err", i), res_err, 0);
            release_res();
        end

        // Ack stall (3 extra cycles per slice) then backpressure.
        ack_delay = 3;
        @(negedge clk);
        op_a = 64'h4444_3333_2222_1111; op_b = 64'h0000_0000_0000_FFFF; op_cin = 0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("stall_add_a", add_a, 16'h1111);
            chk("stall_add_b", add_b, 16'hFFFF);
            chk("stall_listen", add_carry_listen, 1);
            @(posedge clk); #1;
        end
        chk("slice1_add_a", add_a, 16'h2222);
        chk("slice1_carry_in", add_carry_in, 1);
        lat = 4;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_latency", lat, 16);
        chk("stall_sum", res_sum, 64'h4444_3333_2223_1110);
        chk("stall_cout", res_cout, 0);
        held = res_sum;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start_valid = 1'b1; op_a = 64'hDEAD_BEEF_0000_0001; op_b = 64'h5;
            @(posedge clk); #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_sum", res_sum, held);
            chk("bp_start_ready", start_ready, 0);
        end
        @(negedge clk) start_valid = 1'b0;
        release_res();
        @(posedge clk); #1;
        chk("bp_ignored_start", add_on_off, 0);

        // Reset in the middle of an operation (idx=2).
        ack_delay = 0;
        @(negedge clk);
        op_a = 64'hAAAA_BBBB_CCCC_DDDD; op_b = 64'h1; op_cin = 0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_idx2_add_a", add_a, 16'hBBBB);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", start_ready, 1);
        chk("mid_rst_on_off", add_on_off, 0);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_sum", res_sum, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("mid_no_valid", res_valid, 0);
        do_op(vecs[2].a, vecs[2].b, vecs[2].cin, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_sum", res_sum, vecs[2].sum);
        release_res();

`ifdef CARRY_SEQ_TIMEOUT_EN
        // Adder never acks: abort after 15 BUSY cycles.
        ack_off = 1'b1;
        do_op(64'h1, 64'h2, 1'b0, lat);
        chk("to_latency", lat, 15);
        chk("to_err", res_err, 1);
        chk("to_valid", res_valid, 1);
        chk("to_cout", res_cout, 0);
        chk("to_sum", res_sum, 0);
        ack_off = 1'b0;
        release_res();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000");
        $fatal(1);
    end

endmodule
